// File: rtl/ble_packet_builder_pkg.sv
// Shared constants and types for the BLE link-layer packet builder.
// Holds preamble patterns, field lengths, CRC defaults, FSM encoding and the whitening seed helper.
package ble_packet_builder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_AA   = 3'd2,
      ST_HDR  = 3'd3,
      ST_PLD  = 3'd4,
      ST_CRC  = 3'd5
   } state_t;

   localparam logic [23:0] CRC_POLY_DEF = 24'h00065B;
   localparam logic [23:0] CRC_INIT_ADV = 24'h555555;

   // Patterns are shifted out LSB first.
   localparam logic [7:0] PRE_PAT_AA1 = 8'b1010_1010;
   localparam logic [7:0] PRE_PAT_AA0 = 8'b0101_0101;

   localparam int PRE_BITS = 8;
   localparam int AA_BITS  = 32;
   localparam int HDR_BITS = 16;
   localparam int CRC_BITS = 24;

   localparam logic [5:0] PRE_LAST = 6'(PRE_BITS - 1);
   localparam logic [5:0] AA_LAST  = 6'(AA_BITS - 1);
   localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
   localparam logic [5:0] CRC_LAST = 6'(CRC_BITS - 1);

   // Bit i of the result is LFSR position i: position 0 = 1, positions 1..6 = channel[5..0].
   function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
      return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
   endfunction

endpackage

// File: rtl/ble_crc_whiten.sv
// CRC24 Galois LFSR and x^7+x^4+1 whitening LFSR for the BLE packet builder.
// feed_i=1 clocks the raw bit into the CRC; feed_i=0 shifts the CRC out MSB first.
module ble_crc_whiten
   import ble_packet_builder_pkg::*;
#(
   parameter logic [23:0] CRC_POLY  = CRC_POLY_DEF,
   parameter bit          WHITEN_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [23:0] crc_seed_i,
   input  logic [5:0]  chan_i,
   input  logic        bit_en_i,
   input  logic        feed_i,
   input  logic        raw_bit_i,
   output logic        wbit_o,
   output logic        crc_msb_o
);

   logic [23:0] crc_q, crc_d;
   logic [6:0]  wh_q, wh_d;
   logic        fb;

   always_comb begin
      crc_d = crc_q;
      wh_d  = wh_q;
      fb    = feed_i & (crc_q[23] ^ raw_bit_i);
      if (load_i) begin
         crc_d = crc_seed_i;
         wh_d  = whiten_seed(chan_i);
      end else if (bit_en_i) begin
         crc_d = {crc_q[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
         wh_d  = {wh_q[5], wh_q[4], wh_q[3] ^ wh_q[6], wh_q[2], wh_q[1], wh_q[0], wh_q[6]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= '0;
         wh_q  <= '0;
      end else begin
         crc_q <= crc_d;
         wh_q  <= wh_d;
      end
   end

   assign wbit_o    = raw_bit_i ^ (WHITEN_EN & wh_q[6]);
   assign crc_msb_o = crc_q[23];

endmodule

// File: rtl/ble_packet_builder.sv
// Bit-serial BLE air packet builder feeding the FSK modulator symbol interface.
// state   | meaning
// IDLE    | waiting for tx_start; payload prefetch allowed
// PRE     | 8 preamble bits, pattern chosen by access_addr[0]
// AA      | 32 access-address bits, LSB first
// HDR     | 16 header bits, whitened and fed to CRC
// PLD     | len*8 payload bits, whitened and fed to CRC
// CRC     | 24 CRC bits MSB first, whitened
module ble_packet_builder
   import ble_packet_builder_pkg::*;
#(
   parameter logic [23:0] CRC_POLY  = CRC_POLY_DEF,
   parameter bit          WHITEN_EN = 1'b1,
   parameter int          LEN_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [31:0] access_addr,
   input  logic [23:0] crc_init,
   input  logic [5:0]  channel_idx,
   input  logic [15:0] pdu_hdr,
   input  logic [7:0]  pld_data,
   input  logic        pld_valid,
   output logic        pld_ready,
   input  logic        symDone,
   output logic        start,
   output logic        symVal,
   output logic        busy,
   output logic        tx_done,
   output logic        err_underrun
);

   state_t             state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [7:0]         pre_sr_q, pre_sr_d;
   logic [31:0]        aa_sr_q, aa_sr_d;
   logic [15:0]        hdr_sr_q, hdr_sr_d;
   logic [7:0]         byte_sr_q, byte_sr_d;
   logic [7:0]         hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic               tx_done_q, tx_done_d;
   logic               err_q, err_d;

   logic               accept;
   logic               hold_take;
   logic               cw_load, cw_en, cw_feed;
   logic               raw_bit, wbit, crc_msb;

   ble_crc_whiten #(
      .CRC_POLY  (CRC_POLY),
      .WHITEN_EN (WHITEN_EN)
   ) u_crc_whiten (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cw_load),
      .crc_seed_i (crc_init),
      .chan_i     (channel_idx),
      .bit_en_i   (cw_en),
      .feed_i     (cw_feed),
      .raw_bit_i  (raw_bit),
      .wbit_o     (wbit),
      .crc_msb_o  (crc_msb)
   );

   always_comb begin
      raw_bit = 1'b0;
      case (state_q)
         ST_PRE:  raw_bit = pre_sr_q[0];
         ST_AA:   raw_bit = aa_sr_q[0];
         ST_HDR:  raw_bit = hdr_sr_q[0];
         ST_PLD:  raw_bit = byte_sr_q[0];
         ST_CRC:  raw_bit = crc_msb;
         default: raw_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      pre_sr_d   = pre_sr_q;
      aa_sr_d    = aa_sr_q;
      hdr_sr_d   = hdr_sr_q;
      byte_sr_d  = byte_sr_q;
      tx_done_d  = 1'b0;
      err_d      = 1'b0;
      hold_take  = 1'b0;
      cw_load    = 1'b0;
      cw_en      = 1'b0;
      cw_feed    = 1'b0;
      // The cycle carrying tx_done still blocks a new start.
      accept     = (state_q == ST_IDLE) && tx_start && !tx_done_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_PRE;
               cnt_d      = '0;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
               len_d      = LEN_W'(pdu_hdr[15:8]);
               pre_sr_d   = access_addr[0] ? PRE_PAT_AA1 : PRE_PAT_AA0;
               aa_sr_d    = access_addr;
               hdr_sr_d   = pdu_hdr;
               cw_load    = 1'b1;
            end
         end
         ST_PRE: begin
            if (symDone) begin
               pre_sr_d = pre_sr_q >> 1;
               cnt_d    = cnt_q + 6'd1;
               if (cnt_q == PRE_LAST) begin
                  state_d = ST_AA;
                  cnt_d   = '0;
               end
            end
         end
         ST_AA: begin
            if (symDone) begin
               aa_sr_d = aa_sr_q >> 1;
               cnt_d   = cnt_q + 6'd1;
               if (cnt_q == AA_LAST) begin
                  state_d = ST_HDR;
                  cnt_d   = '0;
               end
            end
         end
         ST_HDR: begin
            if (symDone) begin
               cw_en    = 1'b1;
               cw_feed  = 1'b1;
               hdr_sr_d = hdr_sr_q >> 1;
               cnt_d    = cnt_q + 6'd1;
               if (cnt_q == HDR_LAST) begin
                  cnt_d = '0;
                  if (len_q == '0) begin
                     state_d = ST_CRC;
                  end else if (hold_full_q) begin
                     state_d    = ST_PLD;
                     byte_sr_d  = hold_q;
                     hold_take  = 1'b1;
                     bit_cnt_d  = '0;
                     byte_cnt_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         ST_PLD: begin
            if (symDone) begin
               cw_en     = 1'b1;
               cw_feed   = 1'b1;
               byte_sr_d = byte_sr_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q == len_q - LEN_W'(1)) begin
                     state_d = ST_CRC;
                     cnt_d   = '0;
                  end else if (hold_full_q) begin
                     byte_sr_d  = hold_q;
                     hold_take  = 1'b1;
                     byte_cnt_d = byte_cnt_q + LEN_W'(1);
                  end else begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         ST_CRC: begin
            if (symDone) begin
               cw_en = 1'b1;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == CRC_LAST) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  tx_done_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (hold_take) begin
         hold_full_d = 1'b0;
      end else if (pld_valid && !hold_full_q) begin
         hold_d      = pld_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         len_q       <= '0;
         pre_sr_q    <= '0;
         aa_sr_q     <= '0;
         hdr_sr_q    <= '0;
         byte_sr_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_done_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         len_q       <= len_d;
         pre_sr_q    <= pre_sr_d;
         aa_sr_q     <= aa_sr_d;
         hdr_sr_q    <= hdr_sr_d;
         byte_sr_q   <= byte_sr_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_done_q   <= tx_done_d;
         err_q       <= err_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign start        = busy;
   // Preamble and access address go out unwhitened.
   assign symVal       = (state_q == ST_HDR || state_q == ST_PLD || state_q == ST_CRC) ? wbit : raw_bit;
   assign pld_ready    = ~hold_full_q;
   assign tx_done      = tx_done_q;
   assign err_underrun = err_q;

endmodule
